// File: rtl/ps2_joypad_map.sv
// PS/2 set-2 scan-code decoder that tracks every mapped key as its own button
// and drives the joypad input register directly. Decoded make/break events
// are also exported for other consumers.
module ps2_joypad_map #(
  parameter int unsigned              N_BUTTONS    = 8,
  parameter logic [9*N_BUTTONS-1:0]   KEYMAP       = {9'h16C, 9'h170, 9'h171, 9'h169,
                                                      9'h175, 9'h172, 9'h16B, 9'h174},
  parameter bit                       MATCH_EXT    = 1'b1,
  parameter bit                       ACTIVE_LOW   = 1'b1,
  parameter int unsigned              HOLD_TIMEOUT = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           ps2_data,
  input  logic                 ps2_hit,
  output logic [N_BUTTONS-1:0] buttons,
  output logic                 evt_valid,
  output logic [7:0]           evt_code,
  output logic                 evt_ext,
  output logic                 evt_break,
  output logic                 evt_mapped
);

  if (N_BUTTONS < 1 || N_BUTTONS > 16) begin : g_bad_n_buttons
    $error("ps2_joypad_map: N_BUTTONS must be in 1..16");
  end

  // Output level of a released button; a pressed button drives the complement.
  localparam logic [N_BUTTONS-1:0] IdleLevel = {N_BUTTONS{ACTIVE_LOW}};

  localparam logic [7:0] BytePause  = 8'hE1;
  localparam logic [7:0] ByteExt    = 8'hE0;
  localparam logic [7:0] ByteBreak  = 8'hF0;
  // Bytes left to discard after E1 to swallow the rest of the Pause sequence.
  localparam logic [2:0] PauseTail  = 3'd7;

  logic                 ext_q, ext_d;
  logic                 brk_q, brk_d;
  logic [2:0]           skip_q, skip_d;
  logic [N_BUTTONS-1:0] btn_q, btn_d;
  logic                 evt_valid_q, evt_valid_d;
  logic [7:0]           evt_code_q, evt_code_d;
  logic                 evt_ext_q, evt_ext_d;
  logic                 evt_break_q, evt_break_d;
  logic                 evt_mapped_q, evt_mapped_d;
  logic [N_BUTTONS-1:0] match;
  logic                 wd_fire;

  // Per-button key match against the incoming byte and the pending E0 flag.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      if ((KEYMAP[9*i +: 8] == ps2_data) && (!MATCH_EXT || (KEYMAP[9*i+8] == ext_q))) begin
        match[i] = 1'b1;
      end
    end
  end

  if (HOLD_TIMEOUT > 0) begin : g_wd
    logic [31:0] wd_q;

    // Idle counter; stops at the timeout so the release-all fires once per idle stretch.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wd_q <= '0;
      end else if (ps2_hit) begin
        wd_q <= '0;
      end else if (wd_q != HOLD_TIMEOUT) begin
        wd_q <= wd_q + 32'd1;
      end
    end

    assign wd_fire = !ps2_hit && (wd_q == HOLD_TIMEOUT - 32'd1);
  end else begin : g_no_wd
    assign wd_fire = 1'b0;
  end

  // Byte parser: prefix flags, Pause swallowing, resets of the key state and final codes.
  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    skip_d       = skip_q;
    btn_d        = btn_q;
    evt_valid_d  = 1'b0;
    evt_code_d   = evt_code_q;
    evt_ext_d    = evt_ext_q;
    evt_break_d  = evt_break_q;
    evt_mapped_d = evt_mapped_q;
    if (ps2_hit) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (ps2_data)
          BytePause: begin
            skip_d = PauseTail;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
          ByteExt:   ext_d = 1'b1;
          ByteBreak: brk_d = 1'b1;
          // Self-test pass, self-test fail and receive errors: the key state is unknown.
          8'hAA, 8'hFC, 8'h00, 8'hFF: begin
            btn_d = IdleLevel;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          // Ack/resend replies can interleave a sequence; leave the flags alone.
          8'hFA, 8'hFE: ;
          default: begin
            for (int unsigned i = 0; i < N_BUTTONS; i++) begin
              if (match[i]) begin
                btn_d[i] = brk_q ? IdleLevel[i] : ~IdleLevel[i];
              end
            end
            evt_valid_d  = 1'b1;
            evt_code_d   = ps2_data;
            evt_ext_d    = ext_q;
            evt_break_d  = brk_q;
            evt_mapped_d = |match;
            ext_d        = 1'b0;
            brk_d        = 1'b0;
          end
        endcase
      end
    end else if (wd_fire) begin
      btn_d = IdleLevel;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      skip_q       <= '0;
      btn_q        <= IdleLevel;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= '0;
      evt_ext_q    <= 1'b0;
      evt_break_q  <= 1'b0;
      evt_mapped_q <= 1'b0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      skip_q       <= skip_d;
      btn_q        <= btn_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      evt_ext_q    <= evt_ext_d;
      evt_break_q  <= evt_break_d;
      evt_mapped_q <= evt_mapped_d;
    end
  end

  assign buttons    = btn_q;
  assign evt_valid  = evt_valid_q;
  assign evt_code   = evt_code_q;
  assign evt_ext    = evt_ext_q;
  assign evt_break  = evt_break_q;
  assign evt_mapped = evt_mapped_q;

endmodule

// File: tb/tb_ps2_joypad_map.sv
// Bench for ps2_joypad_map: directed vector table, hand-written corner cases and
// randomized byte streams checked against a per-button reference model.
module tb_ps2_joypad_map;

  localparam logic [71:0]  KM0 = {9'h16C, 9'h170, 9'h171, 9'h169,
                                  9'h175, 9'h172, 9'h16B, 9'h174};
  localparam logic [143:0] KM1 = {9'h01C, 9'h01B, 9'h023, 9'h01D,
                                  9'h074, 9'h075, 9'h012, 9'h174,
                                  9'h16C, 9'h170, 9'h171, 9'h169,
                                  9'h175, 9'h172, 9'h16B, 9'h174};
  localparam logic [8:0]   KM2 = 9'h01C;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  ps2_data;
  logic        ps2_hit;

  logic [7:0]  btn0;
  logic [15:0] btn1;
  logic [0:0]  btn2;
  logic        v0, v1, v2, x0, x1, x2, b0, b1, b2, m0, m1, m2;
  logic [7:0]  c0, c1, c2;

  always #5 clock = ~clock;

  ps2_joypad_map #(.N_BUTTONS(8), .KEYMAP(KM0), .MATCH_EXT(1'b1), .ACTIVE_LOW(1'b1),
                   .HOLD_TIMEOUT(100)) dut0 (
    .clock(clock), .reset(reset), .ps2_data(ps2_data), .ps2_hit(ps2_hit), .buttons(btn0),
    .evt_valid(v0), .evt_code(c0), .evt_ext(x0), .evt_break(b0), .evt_mapped(m0));

  ps2_joypad_map #(.N_BUTTONS(16), .KEYMAP(KM1), .MATCH_EXT(1'b0), .ACTIVE_LOW(1'b1),
                   .HOLD_TIMEOUT(0)) dut1 (
    .clock(clock), .reset(reset), .ps2_data(ps2_data), .ps2_hit(ps2_hit), .buttons(btn1),
    .evt_valid(v1), .evt_code(c1), .evt_ext(x1), .evt_break(b1), .evt_mapped(m1));

  ps2_joypad_map #(.N_BUTTONS(1), .KEYMAP(KM2), .MATCH_EXT(1'b1), .ACTIVE_LOW(1'b0),
                   .HOLD_TIMEOUT(37)) dut2 (
    .clock(clock), .reset(reset), .ps2_data(ps2_data), .ps2_hit(ps2_hit), .buttons(btn2),
    .evt_valid(v2), .evt_code(c2), .evt_ext(x2), .evt_break(b2), .evt_mapped(m2));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          n_btn   [3] = '{8, 16, 1};
  bit          m_ext   [3] = '{1'b1, 1'b0, 1'b1};
  bit          act_low [3] = '{1'b1, 1'b1, 1'b0};
  int          ht      [3] = '{100, 0, 37};
  logic [8:0]  km      [3][16];
  bit          pressed [3][16];
  logic [7:0]  prefix  [3][$];
  int          skip_m  [3];
  int          idle_m  [3];
  bit          exp_valid [3];
  logic [7:0]  exp_code  [3];
  bit          exp_ext   [3];
  bit          exp_brk   [3];
  bit          exp_map   [3];
  bit          cur_ext, cur_brk, any_hit;

  function automatic logic [15:0] exp_btn(input int d);
    logic [15:0] v = '0;
    for (int i = 0; i < n_btn[d]; i++) v[i] = pressed[d][i] ^ act_low[d];
    return v;
  endfunction

  function automatic logic [15:0] act_btn(input int d);
    if (d == 0) return {8'h00, btn0};
    if (d == 1) return btn1;
    return {15'h0, btn2};
  endfunction

  function automatic logic [11:0] act_evt(input int d);
    if (d == 0) return {v0, c0, x0, b0, m0};
    if (d == 1) return {v1, c1, x1, b1, m1};
    return {v2, c2, x2, b2, m2};
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        for (int i = 0; i < 16; i++) pressed[d][i] = 1'b0;
        prefix[d].delete();
        skip_m[d] = 0;
        idle_m[d] = 0;
        exp_valid[d] = 1'b0;
      end else begin
        exp_valid[d] = 1'b0;
        if (ps2_hit) begin
          idle_m[d] = 0;
          if (skip_m[d] > 0) begin
            skip_m[d]--;
          end else if (ps2_data == 8'hE1) begin
            skip_m[d] = 7;
            prefix[d].delete();
          end else if (ps2_data == 8'hE0 || ps2_data == 8'hF0) begin
            prefix[d].push_back(ps2_data);
          end else if (ps2_data inside {8'hAA, 8'hFC, 8'h00, 8'hFF}) begin
            for (int i = 0; i < 16; i++) pressed[d][i] = 1'b0;
            prefix[d].delete();
          end else if (!(ps2_data inside {8'hFA, 8'hFE})) begin
            cur_ext = 1'b0;
            cur_brk = 1'b0;
            for (int k = 0; k < prefix[d].size(); k++) begin
              if (prefix[d][k] == 8'hE0) cur_ext = 1'b1;
              if (prefix[d][k] == 8'hF0) cur_brk = 1'b1;
            end
            any_hit = 1'b0;
            for (int i = 0; i < n_btn[d]; i++) begin
              if (km[d][i][7:0] == ps2_data && (!m_ext[d] || km[d][i][8] == cur_ext)) begin
                pressed[d][i] = !cur_brk;
                any_hit = 1'b1;
              end
            end
            exp_valid[d] = 1'b1;
            exp_code[d]  = ps2_data;
            exp_ext[d]   = cur_ext;
            exp_brk[d]   = cur_brk;
            exp_map[d]   = any_hit;
            prefix[d].delete();
          end
        end else if (ht[d] > 0) begin
          idle_m[d]++;
          if (idle_m[d] == ht[d]) begin
            for (int i = 0; i < 16; i++) pressed[d][i] = 1'b0;
            prefix[d].delete();
          end
        end
      end
    end
  end

  // Continuous comparison of all three instances against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        logic [11:0] e;
        e = act_evt(d);
        check($sformatf("model d%0d buttons", d), 32'(act_btn(d)), 32'(exp_btn(d)));
        check($sformatf("model d%0d evt_valid", d), 32'(e[11]), 32'(exp_valid[d]));
        if (exp_valid[d]) begin
          check($sformatf("model d%0d evt_fields", d), 32'(e[10:0]),
                32'({exp_code[d], exp_ext[d], exp_brk[d], exp_map[d]}));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0] data;
    logic [7:0] btn;
    logic       v;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       map;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] data, input logic [7:0] btn, input logic v,
                              input logic [7:0] code, input logic ext, input logic brk,
                              input logic map);
    vec_t r;
    r.data = data; r.btn = btn; r.v = v; r.code = code; r.ext = ext; r.brk = brk; r.map = map;
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after the byte was clocked in.
  task automatic send(input logic [7:0] b);
    ps2_data = b;
    ps2_hit  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ps2_hit  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #1 reset = 1'b1;
    ps2_hit = 1'b0;
    @(negedge clock);
    #1 reset = 1'b0;
  endtask

  logic [7:0] pool [24] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF,
                            8'hFC, 8'h74, 8'h75, 8'h6B, 8'h72, 8'h69, 8'h6C, 8'h70,
                            8'h71, 8'h1C, 8'h12, 8'h14, 8'h77, 8'h1B, 8'h23, 8'h1D};

  initial begin
    logic [71:0]  t0;
    logic [143:0] t1;
    t0 = KM0;
    t1 = KM1;
    for (int i = 0; i < 16; i++) begin
      km[0][i] = (i < 8) ? t0[9*i +: 9] : 9'h0;
      km[1][i] = t1[9*i +: 9];
      km[2][i] = (i == 0) ? KM2 : 9'h0;
    end

    reset    = 1'b1;
    ps2_hit  = 1'b0;
    ps2_data = 8'h00;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk_en = 1'b1;

    check("reset d0 buttons", 32'(btn0), 32'hFF);
    check("reset d1 buttons", 32'(btn1), 32'hFFFF);
    check("reset d2 buttons", 32'(btn2), 32'h0);
    check("reset d0 evt", 32'({v0, c0, x0, b0, m0}), 32'h0);

    tbl.push_back(mk(8'hE0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h74, 8'hFE, 1, 8'h74, 1, 0, 1));
    tbl.push_back(mk(8'hE0, 8'hFE, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h75, 8'hF6, 1, 8'h75, 1, 0, 1));
    tbl.push_back(mk(8'hE0, 8'hF6, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h75, 8'hF6, 1, 8'h75, 1, 0, 1));  // typematic repeat
    tbl.push_back(mk(8'hE0, 8'hF6, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 8'hF6, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h74, 8'hF7, 1, 8'h74, 1, 1, 1));
    tbl.push_back(mk(8'hE0, 8'hF7, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 8'hF7, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h75, 8'hFF, 1, 8'h75, 1, 1, 1));
    tbl.push_back(mk(8'hE1, 8'hFF, 0, 8'h00, 0, 0, 0));  // Pause
    tbl.push_back(mk(8'h14, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h77, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'hE1, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h14, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h77, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'hE0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h6B, 8'hFD, 1, 8'h6B, 1, 0, 1));
    tbl.push_back(mk(8'hE0, 8'hFD, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 8'hFD, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h6B, 8'hFF, 1, 8'h6B, 1, 1, 1));
    tbl.push_back(mk(8'h1C, 8'hFF, 1, 8'h1C, 0, 0, 0));  // unmapped key
    tbl.push_back(mk(8'hF0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h1C, 8'hFF, 1, 8'h1C, 0, 1, 0));
    tbl.push_back(mk(8'hE0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'hF0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h74, 8'hFF, 1, 8'h74, 1, 1, 1));  // break of a released key
    tbl.push_back(mk(8'hE0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h12, 8'hFF, 1, 8'h12, 1, 0, 0));  // fake shift
    tbl.push_back(mk(8'hE0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'hFA, 8'hFF, 0, 8'h00, 0, 0, 0));  // ack keeps E0
    tbl.push_back(mk(8'h74, 8'hFE, 1, 8'h74, 1, 0, 1));
    tbl.push_back(mk(8'hE0, 8'hFE, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 8'h00, 0, 0, 0));  // overrun clears all
    tbl.push_back(mk(8'h74, 8'hFF, 1, 8'h74, 0, 0, 0));
    tbl.push_back(mk(8'hE0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h69, 8'hEF, 1, 8'h69, 1, 0, 1));
    tbl.push_back(mk(8'hE0, 8'hEF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h75, 8'hE7, 1, 8'h75, 1, 0, 1));
    tbl.push_back(mk(8'hAA, 8'hFF, 0, 8'h00, 0, 0, 0));  // BAT releases all
    tbl.push_back(mk(8'hE0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(8'h72, 8'hFB, 1, 8'h72, 1, 0, 1));
    tbl.push_back(mk(8'hFC, 8'hFF, 0, 8'h00, 0, 0, 0));

    for (int n = 0; n < tbl.size(); n++) begin
      send(tbl[n].data);
      check($sformatf("vec%0d buttons", n), 32'(btn0), 32'(tbl[n].btn));
      check($sformatf("vec%0d evt_valid", n), 32'(v0), 32'(tbl[n].v));
      if (tbl[n].v) begin
        check($sformatf("vec%0d evt_fields", n), 32'({c0, x0, b0, m0}),
              32'({tbl[n].code, tbl[n].ext, tbl[n].brk, tbl[n].map}));
      end
    end

    // Watchdog: held key survives 99 idle cycles, released on the 100th.
    send(8'hE0);
    send(8'h69);
    check("wd held at hit", 32'(btn0), 32'hEF);
    repeat (99) @(negedge clock);
    check("wd held at 99", 32'(btn0), 32'hEF);
    @(negedge clock);
    check("wd released at 100", 32'(btn0), 32'hFF);
    check("wd no event", 32'(v0), 32'h0);

    // Reset in the middle of E0 F0: the next code is a plain make.
    send(8'hE0);
    send(8'hF0);
    pulse_reset();
    send(8'h74);
    check("midrst d1 buttons", 32'(btn1), 32'hF6FE);
    check("midrst d1 evt", 32'({v1, c1, x1, b1, m1}), 32'({1'b1, 8'h74, 1'b0, 1'b0, 1'b1}));
    check("midrst d0 buttons", 32'(btn0), 32'hFF);
    check("midrst d0 evt", 32'({v0, c0, x0, b0, m0}), 32'({1'b1, 8'h74, 1'b0, 1'b0, 1'b0}));
    send(8'hF0);
    send(8'h74);
    check("dup release d1", 32'(btn1), 32'hFFFF);

    // Randomized byte stream with idle gaps and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        pulse_reset();
      end else if (r < 8) begin
        repeat ($urandom_range(30, 120)) @(negedge clock);
      end else if (r < 30) begin
        @(negedge clock);
      end else if (r < 85) begin
        send(pool[$urandom_range(0, 23)]);
      end else begin
        send(8'($urandom_range(0, 255)));
      end
    end

    repeat (3) @(negedge clock);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_joypad_map.md
Name: ps2_joypad_map

Overview:
Parametrised successor to the single-key PS/2 joystick mapper in the DE0 top level. It decodes the PS/2 scan-code byte stream (set 2) from the keyboard receiver and tracks every mapped key independently, so several buttons can be held at once and releasing one key frees only its own button. It handles E0 (extended) and E1 (Pause) prefixes, exposes decoded key events for future consumers, and drives the Gigatron inreg directly.

Parameters:
N_BUTTONS, 8, number of button outputs (1..16)
KEYMAP, {9'h16C,9'h170,9'h171,9'h169,9'h175,9'h172,9'h16B,9'h174}, packed 9-bit {ext,code} per button; button i uses KEYMAP[9*i+8:9*i]
MATCH_EXT, 1, 1 = the ext flag must match; 0 = ext flag ignored when matching
ACTIVE_LOW, 1, 1 = pressed button drives 0 and idle drives 1 (Gigatron convention)
HOLD_TIMEOUT, 0, release-all watchdog in clock cycles without a received byte; 0 = disabled (max 2^32-1)

Ports:
clock  in  1  system clock (same domain as the PS/2 receiver)
reset  in  1  async, active-high reset
ps2_data  in  8  received byte from the keyboard receiver
ps2_hit  in  1  one-cycle strobe, ps2_data valid
buttons  out  N_BUTTONS  button levels, polarity set by ACTIVE_LOW
evt_valid  out  1  one-cycle pulse when a complete make/break sequence is decoded
evt_code  out  8  final scan code of the event
evt_ext  out  1  event was E0-prefixed
evt_break  out  1  1 = release, 0 = press
evt_mapped  out  1  event matched at least one KEYMAP entry

Behaviour:
- Reset (async assert, sync release): all buttons released (all-ones if ACTIVE_LOW, else zero). ext_f=0, brk_f=0, skip=0, watchdog=0. evt_* outputs are 0.
- Bytes are consumed only on clock edges where ps2_hit=1. All outputs are registered. Latency is 1 cycle from the final byte's ps2_hit to buttons/evt_* updating.
- Parser, evaluated in priority order when ps2_hit=1:
  1. skip>0: discard the byte, skip--. This absorbs the Pause sequence E1 14 77 E1 F0 14 F0 77.
  2. 8'hE1: skip<=7. ext_f and brk_f are cleared.
  3. 8'hE0: ext_f<=1.
  4. 8'hF0: brk_f<=1.
  5. 8'hAA (BAT), 8'hFC, or 8'h00/8'hFF (error/overrun): release all buttons, clear flags, no event.
  6. 8'hFA/8'hFE (ack/resend): ignored, flags kept.
  7. Any other byte is a final code. Set evt_code=byte, evt_ext=ext_f, evt_break=brk_f, and pulse evt_valid. Every button i whose KEYMAP entry matches (ext compare gated by MATCH_EXT) goes pressed if brk_f=0 or released if brk_f=1. evt_mapped=OR of the matches. Clear ext_f and brk_f.
- Buttons not matched by an event hold their state. Several buttons mapped to the same code all update together.
- Typematic repeat (repeated make of a held key): button stays pressed; evt_valid still pulses with evt_break=0.
- A break for a key that is not pressed is harmless (button stays released); evt_valid still pulses.
- Fake-shift sequences (E0 12, E0 F0 12) decode as ordinary events with ext=1. They are unmapped by default.
- Watchdog (HOLD_TIMEOUT>0): counter clears on every ps2_hit and otherwise increments, saturating. When it reaches HOLD_TIMEOUT, release all buttons once and clear flags. No evt_valid is generated.
- Reset mid-sequence (e.g. after E0 F0): flags cleared. The next final byte is decoded as a plain make.
- The RTL must elaborate for N_BUTTONS=1 and N_BUTTONS=16. An out-of-range N_BUTTONS is a compile-time error.

Test Plan:
- Reset, then E0 74 -> buttons=8'hFE one cycle after the 74 hit; evt_valid=1, evt_code=74, evt_ext=1, evt_break=0, evt_mapped=1.
- E0 74, E0 75, E0 F0 74 -> sequence 8'hFE, 8'hF6, 8'hF7 (only RIGHT released; UP held).
- E1 14 77 E1 F0 14 F0 77, then E0 6B -> no evt_valid during the 8 Pause bytes; afterwards buttons=8'hFD.
- 1C (unmapped A key), then F0 1C -> two evt_valid pulses with evt_mapped=0 and evt_break=0 then 1; buttons stay 8'hFF.
- HOLD_TIMEOUT=100: E0 69, then idle -> buttons=8'hEF until exactly 100 cycles after the hit, then 8'hFF. An AA byte while keys are held -> 8'hFF.
- E0 F0, then reset pulse, then 74 with MATCH_EXT=0 -> buttons=8'hFE (a press, because the flags were cleared by reset).
